// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_DIV_RUN  = 2'b10,
    ST_DONE     = 2'b11
  } md_state_e;

  // LO value written when a divide sees a zero divisor.
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_md_watchdog.sv
// Loadable down-counter that sticks at zero and flags expiry there.
module md_watchdog #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for EX-stage MULT/MULTU/DIV/DIVU: latches operands, drives the
// multiplier or divider, stalls EX while busy and presents a HI/LO result.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_MAX = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        hold,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stallreq,
  output logic        res_valid,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_timeout
);

  localparam int CNT_MAX = (DIV_MAX > MUL_LAT) ? DIV_MAX : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_MAX - 1);

  md_state_e    r_state;
  md_state_e    w_next;
  logic [31:0]  r_a;
  logic [31:0]  r_b;
  logic         r_signed;
  logic [31:0]  r_hi;
  logic [31:0]  r_lo;
  logic         r_timeout;

  logic             w_accept;
  logic             w_div0;
  logic             w_expired;
  logic             w_wd_en;
  logic [CNT_W-1:0] w_wd_load_val;

  assign w_accept      = (r_state == ST_IDLE) && op_valid && !flush;
  assign w_div0        = md_is_div(op) && (src_b == 32'd0);
  assign w_wd_en       = (r_state == ST_MUL_WAIT) || (r_state == ST_DIV_RUN);
  assign w_wd_load_val = md_is_div(op) ? DIV_LOAD : MUL_LOAD;

  // One counter serves both the multiplier latency and the divider watchdog.
  md_watchdog #(
    .W (CNT_W)
  ) u_wd (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_accept),
    .i_load_val (w_wd_load_val),
    .i_en       (w_wd_en),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            if (!md_is_div(op)) w_next = ST_MUL_WAIT;
            else if (w_div0)    w_next = ST_DONE;
            else                w_next = ST_DIV_RUN;
          end
        end
        ST_MUL_WAIT: if (w_expired) w_next = ST_DONE;
        ST_DIV_RUN:  if (div_ready || w_expired) w_next = ST_DONE;
        ST_DONE:     if (!hold) w_next = ST_IDLE;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      ST_IDLE:     stallreq = op_valid && !flush;
      ST_MUL_WAIT: stallreq = 1'b1;
      ST_DIV_RUN: begin
        stallreq  = 1'b1;
        div_start = !flush && !div_ready && !w_expired;
        div_annul = flush || (!div_ready && w_expired);
      end
      ST_DONE:     res_valid = !flush;
      default:     ;
    endcase
  end

  // Operand latches and result capture; flush blocks every capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_timeout <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= md_is_signed(op);
            if (w_div0) begin
              r_hi <= src_a;
              r_lo <= MD_DIV0_LO;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (w_expired) begin
            r_hi <= mul_result[63:32];
            r_lo <= mul_result[31:0];
          end
        end
        ST_DIV_RUN: begin
          if (div_ready) begin
            r_hi <= div_result[63:32];
            r_lo <= div_result[31:0];
          end else if (w_expired) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_signed  = r_signed;
  assign mul_ina     = r_a;
  assign mul_inb     = r_b;
  assign div_signed  = r_signed;
  assign div_opa     = r_a;
  assign div_opb     = r_b;
  assign hi_wdata    = r_hi;
  assign lo_wdata    = r_lo;
  assign div_timeout = r_timeout;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and divider.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush, hold, op_valid;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_ina, mul_inb, div_opa, div_opb, hi_wdata, lo_wdata;
  logic [63:0] mul_result, div_result;
  logic        stallreq, res_valid, div_timeout;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp = '0;
  logic        prev_rv = 1'b0;
  logic        never_ready = 1'b0;
  logic [63:0] w_prod;
  logic [7:0]  dcnt;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(2), .DIV_MAX(40)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .hold(hold),
    .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready), .stallreq(stallreq),
    .res_valid(res_valid), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .div_timeout(div_timeout)
  );

  // Multiplier model: one register stage on the product.
  always_comb begin
    logic [63:0] ea, eb;
    ea = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
    eb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
    w_prod = ea * eb;
  end
  always @(posedge clk) mul_result <= w_prod;

  // Divider model: ready in the 33rd cycle of div_start unless disabled.
  always @(posedge clk) begin
    if (!resetn || div_annul || !div_start) dcnt <= 8'd0;
    else dcnt <= dcnt + 8'd1;
  end
  assign div_ready = !never_ready && (dcnt == 8'd32);
  always_comb begin
    logic signed [31:0] sa, sb;
    sa = div_opa;
    sb = div_opb;
    div_result = '0;
    if (div_opb != 32'd0) begin
      if (div_signed) div_result = {32'(sa % sb), 32'(sa / sb)};
      else            div_result = {div_opa % div_opb, div_opa / div_opb};
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Monitor: pops one expectation per result, then holds it while res_valid stays high.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_rv = 1'b0;
    end else if (res_valid) begin
      if (!prev_rv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got hi=%h lo=%h want none", hi_wdata, lo_wdata);
        end else begin
          cur_exp = exp_q.pop_front();
          check("sb_result", {hi_wdata, lo_wdata}, cur_exp);
        end
      end else begin
        check("sb_hold_stable", {hi_wdata, lo_wdata}, cur_exp);
      end
      prev_rv = 1'b1;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] a, b,
                       input logic [31:0] ehi, elo, input int estall, estart, eannul,
                       input int hold_cycles);
    int n_st, n_sa, n_an, n_rv;
    logic got;
    exp_q.push_back({ehi, elo});
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    n_st = 0; n_sa = 0; n_an = 0; got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (res_valid) begin got = 1'b1; break; end
      if (stallreq)  n_st++;
      if (div_start) n_sa++;
      if (div_annul) n_an++;
      @(posedge clk); #1;
      if (c == 0) begin
        src_a = ~a;
        src_b = b + 32'd9;
        if (hold_cycles > 0) hold = 1'b1;
      end
    end
    check({nm, "_done"}, 64'(got), 64'd1);
    n_rv = got ? 1 : 0;
    for (int k = 1; k < hold_cycles; k++) begin
      @(posedge clk); #1;
      op_valid = ~op_valid;
      @(negedge clk);
      if (res_valid) n_rv++;
    end
    @(posedge clk); #1;
    hold = 1'b0; op_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (res_valid) n_rv++;
    end
    check({nm, "_stall_cycles"}, 64'(n_st), 64'(estall));
    if (estart >= 0) check({nm, "_start_cycles"}, 64'(n_sa), 64'(estart));
    check({nm, "_annul_cycles"}, 64'(n_an), 64'(eannul));
    check({nm, "_resvalid_cycles"}, 64'(n_rv), 64'((hold_cycles > 0) ? hold_cycles + 1 : 1));
    check({nm, "_idle_stall"}, 64'(stallreq), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n_rv;
    resetn = 1'b0; flush = 1'b0; hold = 1'b0; op_valid = 1'b0;
    op = MD_MULT; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {59'd0, stallreq, res_valid, div_start, div_annul, div_timeout}, 64'd0);
    check("reset_hilo", {hi_wdata, lo_wdata}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    issue("mult_neg",   MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 3, 0, 0, 0);
    issue("divu_100_7", MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 34, 32, 0, 0);
    issue("div_by_zero", MD_DIV,  32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1, 0, 0, 0);
    issue("multu_hold", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 3, 0, 0, 3);
    issue("div_signed", MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 32, 0, 0);

    // Flush ten cycles into a divide.
    @(posedge clk); #1;
    op_valid = 1'b1; op = MD_DIV; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_annul_pulse", {62'd0, div_annul, div_start}, 64'd2);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("flush_after", {61'd0, stallreq, res_valid, div_annul}, 64'd0);
    n_rv = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid || div_start) n_rv++;
    end
    check("flush_quiet", 64'(n_rv), 64'd0);
    check("flush_no_timeout", 64'(div_timeout), 64'd0);

    // Divider that never answers.
    never_ready = 1'b1;
    issue("div_timeout", MD_DIVU, 32'd5, 32'd1, 32'd0, 32'd0, 41, -1, 1, 0);
    never_ready = 1'b0;
    check("timeout_set", 64'(div_timeout), 64'd1);
    issue("mult_after_to", MD_MULT, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 3, 0, 0, 0);
    check("timeout_sticky", 64'(div_timeout), 64'd1);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    op_valid = 1'b1; op = MD_DIVU; src_a = 32'd50; src_b = 32'd5;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0; op_valid = 1'b0;
    #1;
    check("midreset_ctrl", {59'd0, stallreq, res_valid, div_start, div_annul, div_timeout}, 64'd0);
    check("midreset_regs", {div_opa, div_opb}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    issue("mult_post_reset", MD_MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 3, 0, 0, 0);
    check("timeout_cleared", 64'(div_timeout), 64'd0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the EX-stage multiply/divide resources.
- Accepts one MULT/MULTU/DIV/DIVU op from EX and latches its operands.
- Drives the pipelined multiplier or the iterative divider, raises the EX stall request while busy, then presents a one-cycle HI/LO write result.
- Owns divide-by-zero handling, flush/annul, and a divider watchdog, so EX no longer builds divider control combinationally.

Parameters:
- MUL_LAT, 2, multiplier result latency in cycles after operands are applied (1..7).
- DIV_MAX, 40, watchdog limit in cycles for divider ready.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill in-flight op (exception/redirect)
- hold  in  1  pipeline frozen by another stall source; EX instruction does not advance
- op_valid  in  1  EX holds a mul/div op
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- mul_signed  out  1  to multiplier
- mul_ina  out  32  to multiplier
- mul_inb  out  32  to multiplier
- mul_result  in  64  from multiplier
- div_start  out  1  to divider
- div_signed  out  1  to divider
- div_opa  out  32  to divider
- div_opb  out  32  to divider
- div_annul  out  1  to divider
- div_result  in  64  {remainder, quotient} from divider
- div_ready  in  1  divider result valid
- stallreq  out  1  EX stall request
- res_valid  out  1  HI/LO write strobe
- hi_wdata  out  32  HI write data
- lo_wdata  out  32  LO write data
- div_timeout  out  1  sticky watchdog error

Behaviour:
- Reset: asynchronous on resetn low. State IDLE, all registers 0, every output 0.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- Operands and sign mode are latched on acceptance. mul_*/div_* outputs come from these latches, not from src_a/src_b.

IDLE:
- stallreq = op_valid & ~flush (combinational), so the first cycle already stalls.
- op_valid & ~flush with op MULT/MULTU: latch operands, go to MUL_WAIT, cnt = MUL_LAT-1.
- op DIV/DIVU with src_b == 0: go straight to DONE with hi = src_a, lo = 32'hFFFF_FFFF. This is the defined result; the divider is not started.
- op DIV/DIVU otherwise: latch operands, go to DIV_RUN. div_start is 1 in the DIV_RUN cycles only.

MUL_WAIT:
- stallreq = 1.
- Decrement cnt. When cnt == 0, capture mul_result into hi/lo and go to DONE.
- Total stall is MUL_LAT+1 cycles including the IDLE acceptance cycle.

DIV_RUN:
- stallreq = 1, div_start = 1.
- On div_ready: capture hi = div_result[63:32], lo = div_result[31:0], drop div_start, go to DONE.
- A watchdog counts cycles. On reaching DIV_MAX without ready: div_annul pulses 1 cycle, div_timeout is set (sticky until reset), result is forced to hi = 0, lo = 0, go to DONE.

DONE:
- stallreq = 0, res_valid = 1, hi/lo stable.
- If hold = 1, stay in DONE. res_valid stays high and the consumer must treat it as a level until the instruction advances.
- Else return to IDLE. The op_valid seen in that next IDLE cycle belongs to the next instruction.

Flush:
- flush = 1 in any state goes to IDLE next cycle, and res_valid is forced 0 that cycle.
- In DIV_RUN it also pulses div_annul for 1 cycle and drops div_start.
- Flush has priority over ready, watchdog and acceptance in the same cycle.

Other rules:
- op_valid is ignored outside IDLE. op/src changes mid-operation have no effect.
- Reset mid-operation returns to IDLE immediately; outputs are 0 on the next clock edge observation.

Decomposition:
- Shared defines header holds: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state encodings, and the divide-by-zero LO constant.
- One sub-module is natural: md_watchdog, a loadable down-counter with an expire flag, reused for both the MUL_WAIT latency count and the DIV_MAX watchdog.

Test Plan:
- MULT src_a = -3, src_b = 5, MUL_LAT = 2, model multiplier → stallreq high 3 cycles, then res_valid 1 cycle with hi = FFFFFFFF, lo = FFFFFFF1.
- DIVU 100 / 7, divider ready after 33 cycles → stallreq high through the ready cycle, then res_valid with hi = 2, lo = 14; div_start drops with ready.
- DIV src_b = 0, src_a = 0x1234 → DONE on the next cycle with hi = 0x1234, lo = FFFFFFFF; div_start never asserts.
- flush asserted 10 cycles into DIV_RUN → div_annul one-cycle pulse, IDLE next cycle, no res_valid, stallreq low.
- Divider that never asserts ready → after 40 cycles div_timeout = 1, div_annul pulse, res_valid with hi = lo = 0; div_timeout stays set until resetn low.
- hold = 1 for 3 cycles while in DONE → res_valid and hi/lo stable for all 3 cycles; an op_valid toggle is ignored; IDLE after hold drops.
